slt_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared set-less-than comparator of the CPU datapath. Two independent clients, such as the ALU issue path and a branch/trap-compare path, present compare requests with a valid/ready handshake. The block grants one request per cycle, drives it into a single combinational comparator and returns a registered result tagged with the requester ID. Results leave through one response channel with backpressure.

---
 rtl/slt_pkg.sv | 26 ++
 rtl/slt_core.sv | 33 +++
 rtl/slt_arbiter.sv | 138 +++++++++++++
 tb/tb_slt_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/slt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slt_pkg
//  Description : Shared types and constants for the set-less-than arbiter
//                and its comparator core.
//  Revision    : 1.0 - initial release
// ============================================================================
package slt_pkg;

    // Compare mode encoding carried on req_sgn
    localparam logic CMP_UNSIGNED = 1'b0;
    localparam logic CMP_SIGNED   = 1'b1;

    // Requester index (two requesters)
    typedef logic req_id_t;

    // Registered response payload
    typedef struct packed {
        req_id_t id;
        logic    r;
        logic    zero;
        logic    carry;
    } slt_rsp_t;

endpackage
`default_nettype wire

// File: rtl/slt_core.sv
`default_nettype none
// ============================================================================
//  Module      : slt_core
//  Description : Combinational set-less-than comparator, signed or unsigned.
//                carry mirrors r for unsigned compares and is 0 for signed.
//  Revision    : 1.0 - initial release
// ============================================================================
module slt_core
    import slt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic             r,
    output logic             zero,
    output logic             carry
);

    // Compare a < b in the requested number system and derive the flags
    always_comb begin
        if (sgn == CMP_SIGNED) begin
            r = ($signed(a) < $signed(b));
        end else begin
            r = (a < b);
        end
        zero  = ~r;
        carry = (sgn == CMP_UNSIGNED) ? r : 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/slt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : slt_arbiter
//  Description : Two-requester arbiter in front of one shared slt comparator.
//                One grant per cycle, registered result tagged with the
//                requester id, single response channel with backpressure.
//                Macro SLT_ARB_RR_EN: defined -> round-robin arbitration,
//                undefined -> fixed priority (requester 0 wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module slt_arbiter
    import slt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [1:0]       req_sgn,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_zero,
    output logic             rsp_carry
);

    localparam slt_rsp_t RSP_RESET = '{id: 1'b0, r: 1'b0, zero: 1'b1, carry: 1'b0};

    logic             slot_free;
    logic             grant_any;
    logic             accept;
    req_id_t          grant_id;

    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_sgn;
    logic             cmp_r;
    logic             cmp_zero;
    logic             cmp_carry;

    logic             rsp_valid_q;
    logic             rsp_valid_d;
    slt_rsp_t         rsp_q;
    slt_rsp_t         rsp_d;

`ifdef SLT_ARB_RR_EN
    req_id_t          rr_ptr_q;
    req_id_t          rr_ptr_d;
`endif

    // The output slot can take a new result when empty or being drained now
    assign slot_free = ~rsp_valid_q | rsp_ready;

    // Choose the winner from the valid bits only; operands never matter
    always_comb begin
        grant_any = |req_valid;
`ifdef SLT_ARB_RR_EN
        if (req_valid == 2'b11) begin
            grant_id = rr_ptr_q;
        end else begin
            grant_id = req_valid[1];
        end
`else
        grant_id = ~req_valid[0];
`endif
    end

    assign accept    = slot_free & grant_any;
    assign req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    // Steer the granted requester's operands into the shared comparator
    always_comb begin
        cmp_a   = grant_id ? req_a1 : req_a0;
        cmp_b   = grant_id ? req_b1 : req_b0;
        cmp_sgn = req_sgn[grant_id];
    end

    slt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (cmp_a),
        .b     (cmp_b),
        .sgn   (cmp_sgn),
        .r     (cmp_r),
        .zero  (cmp_zero),
        .carry (cmp_carry)
    );

    // Next response state: load on accept, clear valid on plain retire, else hold
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_d       = '{id: grant_id, r: cmp_r, zero: cmp_zero, carry: cmp_carry};
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

`ifdef SLT_ARB_RR_EN
    // After an accepted transfer the other requester becomes preferred
    always_comb begin
        rr_ptr_d = accept ? ~grant_id : rr_ptr_q;
    end
`endif

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= RSP_RESET;
`ifdef SLT_ARB_RR_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
`ifdef SLT_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_q.id;
    assign rsp_r     = {{(WIDTH-1){1'b0}}, rsp_q.r};
    assign rsp_zero  = rsp_q.zero;
    assign rsp_carry = rsp_q.carry;

endmodule
`default_nettype wire

// File: tb/tb_slt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slt_arbiter
//  Description : Directed self-checking bench for slt_arbiter. Arbitration
//                expectations follow SLT_ARB_RR_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slt_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_sgn;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_r;
    logic        rsp_zero;
    logic        rsp_carry;

    int checks = 0;
    int errors = 0;

    slt_arbiter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_sgn   (req_sgn),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout sim time exceeded");
        $fatal(1, "timeout");
    end

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1; req_sgn = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        #12;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rst_id got %b exp 0", rsp_id); end
        checks++; if (rsp_r !== 32'd0) begin errors++; $display("FAIL rst_r got %h exp 0", rsp_r); end
        checks++; if (rsp_zero !== 1'b1) begin errors++; $display("FAIL rst_zero got %b exp 1", rsp_zero); end
        checks++; if (rsp_carry !== 1'b0) begin errors++; $display("FAIL rst_carry got %b exp 0", rsp_carry); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", req_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1; req_sgn = 2'b00; req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL uns_ready got %b exp 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL uns_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL uns_id got %b exp 0", rsp_id); end
        checks++; if (rsp_r !== 32'd0) begin errors++; $display("FAIL uns_r got %h exp 0", rsp_r); end
        checks++; if (rsp_zero !== 1'b1) begin errors++; $display("FAIL uns_zero got %b exp 1", rsp_zero); end
        checks++; if (rsp_carry !== 1'b0) begin errors++; $display("FAIL uns_carry got %b exp 0", rsp_carry); end
        // reversed operands: 1 < FFFFFFFF unsigned
        req_a0 = 32'd1; req_b0 = 32'hFFFF_FFFF; req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (rsp_r !== 32'd1) begin errors++; $display("FAIL uns2_r got %h exp 1", rsp_r); end
        checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL uns2_zero got %b exp 0", rsp_zero); end
        checks++; if (rsp_carry !== 1'b1) begin errors++; $display("FAIL uns2_carry got %b exp 1", rsp_carry); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL uns_retire got %b exp 0", rsp_valid); end
    endtask

    task automatic test_signed;
        req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_sgn = 2'b10; req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL sgn_ready got %b exp 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL sgn_id got %b exp 1", rsp_id); end
        checks++; if (rsp_r !== 32'd1) begin errors++; $display("FAIL sgn_r got %h exp 1", rsp_r); end
        checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL sgn_zero got %b exp 0", rsp_zero); end
        checks++; if (rsp_carry !== 1'b0) begin errors++; $display("FAIL sgn_carry got %b exp 0", rsp_carry); end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration;
        logic [1:0] exp_ready;
        logic       exp_id;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        req_a0 = 32'd0; req_b0 = 32'd5; req_a1 = 32'd5; req_b1 = 32'd0;
        req_sgn = 2'b10; req_valid = 2'b11; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef SLT_ARB_RR_EN
            exp_id = i[0];
`else
            exp_id = 1'b0;
`endif
            exp_ready = exp_id ? 2'b10 : 2'b01;
            #1;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL arb_ready[%0d] got %b exp %b", i, req_ready, exp_ready); end
            @(posedge clk); #1;
            checks++; if (rsp_id !== exp_id || rsp_valid !== 1'b1) begin errors++; $display("FAIL arb_id[%0d] got id %b valid %b exp id %b valid 1", i, rsp_id, rsp_valid, exp_id); end
            checks++; if (rsp_r !== {31'd0, ~exp_id}) begin errors++; $display("FAIL arb_r[%0d] got %h exp %h", i, rsp_r, {31'd0, ~exp_id}); end
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [4] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] tb [4] = '{32'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic        ts [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        tr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a0 = ta[i]; req_b0 = tb[i]; req_sgn = {1'b0, ts[i]}; req_valid = 2'b01;
            #1;
            checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 01", i, req_ready); end
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_r !== {31'd0, tr[i]}) begin errors++; $display("FAIL b2b_r[%0d] got valid %b r %h exp valid 1 r %h", i, rsp_valid, rsp_r, {31'd0, tr[i]}); end
            checks++; if (rsp_carry !== tc[i] || rsp_zero !== ~tr[i]) begin errors++; $display("FAIL b2b_flags[%0d] got c %b z %b exp c %b z %b", i, rsp_carry, rsp_zero, tc[i], ~tr[i]); end
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_retire got %b exp 0", rsp_valid); end
    endtask

    task automatic test_backpressure;
        logic [1:0] exp_ready;
        logic       exp_id, exp_r, exp_c;
        rsp_ready = 1'b1;
        req_a0 = 32'd3; req_b0 = 32'd7; req_sgn = 2'b00; req_valid = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_a0 = 32'd9; req_b0 = 32'd2; req_a1 = 32'd0; req_b1 = 32'd1;
        req_sgn = 2'b10; req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready0 got %b exp 00", req_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 00", i, req_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_r !== 32'd1 || rsp_zero !== 1'b0 || rsp_carry !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d] got v%b id%b r%h z%b c%b exp v1 id0 r1 z0 c1", i, rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_carry);
            end
        end
`ifdef SLT_ARB_RR_EN
        exp_id = 1'b1; exp_r = 1'b1; exp_c = 1'b0;
`else
        exp_id = 1'b0; exp_r = 1'b0; exp_c = 1'b0;
`endif
        exp_ready = exp_id ? 2'b10 : 2'b01;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL bp_release_ready got %b exp %b", req_ready, exp_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_r !== {31'd0, exp_r} || rsp_carry !== exp_c || rsp_zero !== ~exp_r) begin
            errors++; $display("FAIL bp_release got v%b id%b r%h c%b z%b exp v1 id%b r%b c%b z%b", rsp_valid, rsp_id, rsp_r, rsp_carry, rsp_zero, exp_id, exp_r, exp_c, ~exp_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        rsp_ready = 1'b1;
        req_a0 = 32'd3; req_b0 = 32'd7; req_sgn = 2'b00; req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00; rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_r !== 32'd1) begin errors++; $display("FAIL ar_pre got v%b r%h exp v1 r1", rsp_valid, rsp_r); end
        #2; rst_n = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_zero !== 1'b1 || rsp_r !== 32'd0 || rsp_carry !== 1'b0 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL ar_rsp got z%b r%h c%b id%b exp z1 r0 c0 id0", rsp_zero, rsp_r, rsp_carry, rsp_id);
        end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL ar_ready got %b exp 00", req_ready); end
        @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_post got %b exp 0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_arbitration();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
